// File: rtl/serial_sub_7bit.sv
// Bit-serial subtractor: computes A - B - bin one bit per clock, LSB first.
// A three-state FSM (IDLE/SHIFT/DONE) sequences the operation; results are
// loaded in one step on the final SHIFT edge and held until the next completion.
module serial_sub_7bit #(
    parameter int width = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [width:1] A,
    input  logic [width:1] B,
    input  logic           bin,
    output logic [width:1] D,
    output logic           bout,
    output logic           ovf,
    output logic           busy,
    output logic           done
);

    localparam int IW = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [width:1] a_sr;
    logic [width:1] b_sr;
    logic [width:1] d_sr;
    logic           br;
    logic [IW-1:0]  idx;

    logic           a_i;
    logic           b_i;
    logic           d_i;
    logic           br_next;
    logic           last;

    // Single-bit full-subtractor on the current LSBs of the shift registers
    always_comb begin
        a_i     = a_sr[1];
        b_i     = b_sr[1];
        d_i     = a_i ^ b_i ^ br;
        br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        last    = (idx == IW'(width));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; busy/done decode the registered state only
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            br   <= 1'b0;
            idx  <= '0;
            D    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        br   <= bin;
                        idx  <= IW'(1);
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    d_sr <= {d_i, d_sr[width:2]};
                    idx  <= idx + IW'(1);
                    // On the MSB edge, br is the borrow into bit width, so
                    // overflow is br XOR the outgoing borrow.
                    if (last) begin
                        D    <= {d_i, d_sr[width:2]};
                        bout <= br_next;
                        ovf  <= br ^ br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_sub_7bit.md
SERIAL_SUB_7BIT -- requirements
Module: serial_sub_7bit

Interface
REQ-001 SHALL have parameter width, default 7, giving the operand and result width in bits; operand and result buses are indexed [width:1], with bit 1 as the LSB.
REQ-002 SHALL have port clk  input  1  system clock; every register is updated on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to start an operation; sampled only in IDLE.
REQ-005 SHALL have port A  input  width  minuend; sampled on the edge that accepts start.
REQ-006 SHALL have port B  input  width  subtrahend; sampled on the edge that accepts start.
REQ-007 SHALL have port bin  input  1  borrow-in; sampled on the edge that accepts start.
REQ-008 SHALL have port D  output  width  difference A - B - bin, modulo 2^width.
REQ-009 SHALL have port bout  output  1  borrow-out from bit width; 1 when A < B + bin (unsigned).
REQ-010 SHALL have port ovf  output  1  two's-complement overflow: borrow into bit width XOR bout.
REQ-011 SHALL have port busy  output  1  high while the block is in SHIFT.
REQ-012 SHALL have port done  output  1  one-cycle pulse, high while the block is in DONE.

Function
REQ-013 SHALL implement a three-state machine with states IDLE, SHIFT and DONE.
REQ-014 SHALL, in IDLE with start=1, on the next edge: latch A, B and bin into internal shift registers, set bit index to 1, and go to SHIFT.
REQ-015 SHALL, in IDLE with start=0, stay in IDLE.
REQ-016 SHALL, on each edge in SHIFT, process exactly one bit i (LSB first) as d_i = a_i ^ b_i ^ br and br' = (~a_i & b_i) | (~(a_i ^ b_i) & br), where br starts as the latched bin.
REQ-017 SHALL, on the edge that processes bit width: load D, bout and ovf together and go to DONE; SHIFT therefore lasts exactly width cycles.
REQ-018 SHALL go from DONE to IDLE on the next edge unconditionally; done is high for exactly one cycle.
REQ-019 SHALL give a latency of width+1 cycles: with start accepted at edge k, done is high in the cycle after edge k+width.
REQ-020 SHALL ignore start in SHIFT and in DONE, with no effect on the operation in progress; the earliest new acceptance is the first IDLE cycle after done.
REQ-021 SHALL hold D, bout and ovf stable from the DONE load until the next completion; they do not change during SHIFT.
REQ-022 SHALL ignore changes on A, B and bin after acceptance.
REQ-023 SHALL compute D exactly as (A - B - bin) mod 2^width for every input combination, including A=B with bin=1 (D all-ones, bout=1).
REQ-024 SHALL take busy and done only from registered state, never combinationally from start.

Reset
REQ-025 SHALL, while rst=1, immediately force: state=IDLE, D=0, bout=0, ovf=0, busy=0, done=0, internal shift registers, borrow and index = 0.
REQ-026 SHALL abort any operation in progress when rst is asserted mid-SHIFT or in DONE; no done pulse follows, and outputs read the reset values.
REQ-027 SHALL, after rst deasserts, accept start on the first rising edge at which start=1.

Verification
REQ-028 SHALL cover: A=10, B=3, bin=0 -> done at the 8th edge after acceptance; D=7, bout=0, ovf=0.
REQ-029 SHALL cover: A=3, B=10, bin=0 -> D=0x79 (121), bout=1, ovf=0.
REQ-030 SHALL cover: A=0x40 (-64), B=1, bin=0 -> D=0x3F, bout=0, ovf=1; and A=0, B=0, bin=1 -> D=0x7F, bout=1, ovf=0.
REQ-031 SHALL cover: start re-pulsed with new operands during SHIFT and during DONE -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-032 SHALL cover: rst pulsed at the 4th SHIFT cycle -> all outputs 0 immediately, no done pulse; a new start afterwards completes correctly.
REQ-033 SHALL cover: back-to-back operations (start held high) -> accepted on every IDLE edge, giving one done pulse every width+2 cycles with correct results.
